// File: rtl/corr_pkg.sv
// Shared constants and width helpers for the streaming correlation block.
// Imported by the accumulator FSM and its finalize datapath.
package corr_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd1;
  localparam logic [2:0] S_FIN_XY = 3'd2;
  localparam logic [2:0] S_FIN_XX = 3'd3;
  localparam logic [2:0] S_FIN_YY = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_XY   = 2'd1;
  localparam logic [1:0] OP_XX   = 2'd2;
  localparam logic [1:0] OP_YY   = 2'd3;

  localparam int CORR_SCALE = 1000;

  function automatic int sum_w(input int aw, input int pw);
    return pw + aw;
  endfunction

  function automatic int acc_w(input int aw, input int pw);
    return 2 * pw + aw;
  endfunction

  function automatic int res_w(input int aw, input int pw);
    return 2 * sum_w(aw, pw) + 1;
  endfunction

endpackage

// File: rtl/corr_finalize.sv
// Shared-multiplier finalize datapath: one n*S - A*B product per op,
// holding numerator/denominators and the constant-image flag.
module corr_finalize
  import corr_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int PIX_WIDTH  = 8,
  localparam int SUM_W = sum_w(ADDR_WIDTH, PIX_WIDTH),
  localparam int ACC_W = acc_w(ADDR_WIDTH, PIX_WIDTH),
  localparam int RES_W = res_w(ADDR_WIDTH, PIX_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              op_i,
  input  logic [SUM_W-1:0]        sx_i,
  input  logic [SUM_W-1:0]        sy_i,
  input  logic [ACC_W-1:0]        sxy_i,
  input  logic [ACC_W-1:0]        sxx_i,
  input  logic [ACC_W-1:0]        syy_i,
  output logic signed [RES_W-1:0] numerator_o,
  output logic signed [RES_W-1:0] denom_x_o,
  output logic signed [RES_W-1:0] denom_y_o,
  output logic                    invalid_o
);

  logic [SUM_W-1:0]        mul_a;
  logic [SUM_W-1:0]        mul_b;
  logic [ACC_W-1:0]        acc_sel;
  logic [2*SUM_W-1:0]      prod;
  logic signed [RES_W-1:0] shifted;
  logic signed [RES_W-1:0] prod_x;
  logic signed [RES_W-1:0] diff;

  logic signed [RES_W-1:0] num_q;
  logic signed [RES_W-1:0] dx_q;
  logic signed [RES_W-1:0] dy_q;
  logic                    inv_q;

  always_comb begin
    mul_a   = sx_i;
    mul_b   = sy_i;
    acc_sel = sxy_i;
    unique case (1'b1)
      (op_i == OP_XX): begin
        mul_a   = sx_i;
        mul_b   = sx_i;
        acc_sel = sxx_i;
      end
      (op_i == OP_YY): begin
        mul_a   = sy_i;
        mul_b   = sy_i;
        acc_sel = syy_i;
      end
      default: begin
        mul_a   = sx_i;
        mul_b   = sy_i;
        acc_sel = sxy_i;
      end
    endcase
  end

  assign prod = {{SUM_W{1'b0}}, mul_a}
              * {{SUM_W{1'b0}}, mul_b};

  // n is a power of two, so n*S is a left shift
  assign shifted = $signed({1'b0, acc_sel,
                            {ADDR_WIDTH{1'b0}}});
  assign prod_x  = $signed({1'b0, prod});
  assign diff    = shifted - prod_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      inv_q <= 1'b0;
    end else begin
      if (op_i == OP_XY) num_q <= diff;
      if (op_i == OP_XX) dx_q <= diff;
      if (op_i == OP_YY) begin
        dy_q  <= diff;
        inv_q <= (dx_q == '0) || (diff == '0);
      end
    end
  end

  assign numerator_o = num_q;
  assign denom_x_o   = dx_q;
  assign denom_y_o   = dy_q;
  assign invalid_o   = inv_q;

endmodule

// File: rtl/corr_stream_accum.sv
// Streaming Pearson-correlation front end: accumulates five sums
// over one image, then sequences the finalize datapath.
module corr_stream_accum
  import corr_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int PIX_WIDTH  = 8,
  localparam int SUM_W = sum_w(ADDR_WIDTH, PIX_WIDTH),
  localparam int ACC_W = acc_w(ADDR_WIDTH, PIX_WIDTH),
  localparam int RES_W = res_w(ADDR_WIDTH, PIX_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_WIDTH-1:0]    x_pix,
  input  logic [PIX_WIDTH-1:0]    y_pix,
  output logic                    busy,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    done,
  output logic signed [RES_W-1:0] numerator,
  output logic signed [RES_W-1:0] denom_x,
  output logic signed [RES_W-1:0] denom_y,
  output logic                    invalid
);

  localparam logic [ADDR_WIDTH:0] LAST =
    (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

  logic [2:0]             state_q, state_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic [SUM_W-1:0]       sx_q, sx_d;
  logic [SUM_W-1:0]       sy_q, sy_d;
  logic [ACC_W-1:0]       sxy_q, sxy_d;
  logic [ACC_W-1:0]       sxx_q, sxx_d;
  logic [ACC_W-1:0]       syy_q, syy_d;
  logic                   done_q;
  logic [1:0]             op;
  logic                   accept;
  logic [2*PIX_WIDTH-1:0] pxy, pxx, pyy;

  assign in_ready = (state_q == S_ACCUM);
  assign busy     = (state_q == S_ACCUM)
                 || (state_q == S_FIN_XY)
                 || (state_q == S_FIN_XX)
                 || (state_q == S_FIN_YY);
  // start wins over a coincident beat
  assign accept   = in_valid & in_ready & ~start;

  assign pxy = {{PIX_WIDTH{1'b0}}, x_pix}
             * {{PIX_WIDTH{1'b0}}, y_pix};
  assign pxx = {{PIX_WIDTH{1'b0}}, x_pix}
             * {{PIX_WIDTH{1'b0}}, x_pix};
  assign pyy = {{PIX_WIDTH{1'b0}}, y_pix}
             * {{PIX_WIDTH{1'b0}}, y_pix};

  always_comb begin
    state_d = state_q;
    op      = OP_NONE;
    if (start) begin
      state_d = S_ACCUM;
    end else begin
      unique case (1'b1)
        (state_q == S_ACCUM): begin
          if (accept && count_q == LAST)
            state_d = S_FIN_XY;
        end
        (state_q == S_FIN_XY): begin
          op      = OP_XY;
          state_d = S_FIN_XX;
        end
        (state_q == S_FIN_XX): begin
          op      = OP_XX;
          state_d = S_FIN_YY;
        end
        (state_q == S_FIN_YY): begin
          op      = OP_YY;
          state_d = S_DONE;
        end
        (state_q == S_DONE): begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sxy_d   = sxy_q;
    sxx_d   = sxx_q;
    syy_d   = syy_q;
    if (start) begin
      count_d = '0;
      sx_d    = '0;
      sy_d    = '0;
      sxy_d   = '0;
      sxx_d   = '0;
      syy_d   = '0;
    end else if (accept) begin
      count_d = count_q + 1'b1;
      sx_d    = sx_q + {{ADDR_WIDTH{1'b0}}, x_pix};
      sy_d    = sy_q + {{ADDR_WIDTH{1'b0}}, y_pix};
      sxy_d   = sxy_q + {{ADDR_WIDTH{1'b0}}, pxy};
      sxx_d   = sxx_q + {{ADDR_WIDTH{1'b0}}, pxx};
      syy_d   = syy_q + {{ADDR_WIDTH{1'b0}}, pyy};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      sxy_q   <= '0;
      sxx_q   <= '0;
      syy_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sxy_q   <= sxy_d;
      sxx_q   <= sxx_d;
      syy_q   <= syy_d;
      done_q  <= (state_q == S_DONE) & ~start;
    end
  end

  assign count = count_q;
  assign done  = done_q;

  corr_finalize #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PIX_WIDTH  (PIX_WIDTH)
  ) u_fin (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_i        (op),
    .sx_i        (sx_q),
    .sy_i        (sy_q),
    .sxy_i       (sxy_q),
    .sxx_i       (sxx_q),
    .syy_i       (syy_q),
    .numerator_o (numerator),
    .denom_x_o   (denom_x),
    .denom_y_o   (denom_y),
    .invalid_o   (invalid)
  );

endmodule
